mdu_issue_ctrl: RTL and testbench
=================================

# mdu_issue_ctrl

Pipeline-side initiator for the multiply/divide unit, located in the E stage between the decoded instruction and the MDU. It issues `mult`/`multu`/`div`/`divu` to the MDU with a single-cycle start pulse. It keeps a cycle-exact shadow of the MDU's busy window and produces the D-stage stall for HI/LO-class instructions. Under a compile option it also checks the MDU's `Busy` response against that shadow.

## Interface
- `MULT_LAT`, 5: MDU busy cycles after a mult/multu start.
- `DIV_LAT`, 10: MDU busy cycles after a div/divu start.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `req` in 1: exception/interrupt request. Freezes MDU progress and suppresses issue.
- `d_md` in 1: the D-stage instruction is MD-class (mult/multu/div/divu/mfhi/mflo/mthi/mtlo).
- `e_valid` in 1: the E-stage instruction is valid.
- `e_op` in 4: E-stage MDU op, using the shared encoding: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo.
- `e_srca`, `e_srcb` in 32: forwarded E-stage operands.
- `mdu_busy` in 1: `Busy` returned from the MDU.
- `mdu_start` out 1: start pulse to the MDU.
- `mdu_op` out 4: op to the MDU.
- `mdu_srca`, `mdu_srcb` out 32: operands to the MDU.
- `stall_d` out 1: freeze F/D and insert a bubble into E.
- `proto_err` out 1: sticky protocol-mismatch flag.

## Operation
- State machine: IDLE, RUN. Counter `cnt` is 4 bits wide and must hold `DIV_LAT`.
- `issue = e_valid & ~req & state==IDLE & e_op∈{1..4}`.
  - `mdu_start = issue`, combinational.
  - `mdu_op = e_valid ? e_op : 0`.
  - Operands pass straight through from `e_srca`/`e_srcb`.
- IDLE → RUN on `issue`:
  - `cnt <= MULT_LAT` for ops 1/2.
  - `cnt <= DIV_LAT` for ops 3/4.
- RUN behaviour each cycle:
  - If `req`: hold `cnt` and state. This mirrors the MDU, which freezes while `Req` is high.
  - Else if `cnt==1`: go to IDLE with `cnt <= 0`.
  - Else: `cnt <= cnt-1`.
- `stall_d = d_md & (issue | state==RUN)`. Non-MD D-stage instructions never stall.
- mfhi/mflo/mthi/mtlo in E generate no start. The stall guarantees they only reach E while the block is IDLE.
- An MD op in E while in RUN is not issued. This is flagged when the checker is compiled in.
- Reset (async, `reset==0`):
  - State IDLE, `cnt=0`, `proto_err=0`.
  - `mdu_start=0` and `stall_d=0` while reset is low, regardless of inputs.

## Timing
- Start at edge t0 → `stall_d` is high in the start cycle plus LAT following cycles:
  - 6 cycles total for mult.
  - 11 cycles total for div.
- The first cycle with `stall_d=0` is the first cycle in which MDU HI/LO hold the new result.
- Each cycle with `req` high during RUN extends the stall by one cycle.
- `req` high in the would-be issue cycle: no start, state stays IDLE. The op is reissued after the pipeline flush.
- Reset mid-RUN: `stall_d` drops immediately (asynchronously). The MDU is reset by the same system reset.

## Configuration
- `MDU_ISSUE_CHECK_EN` defined:
  - A register holds `exp_busy` (1 when in RUN, 0 when in IDLE).
  - Any cycle with `mdu_busy != exp_busy` sets `proto_err`.
  - A valid E-stage op in 1..4 while in RUN also sets `proto_err`.
  - `proto_err` is sticky until reset.
- Not defined: `proto_err` is tied to 0, `mdu_busy` is unused, and no checker logic is generated.

## Test plan
- mult, `e_srca=7`, `e_srcb=-3`, `d_md=1` throughout → `mdu_start` high for exactly 1 cycle, `mdu_op=1`, `stall_d` high for 6 cycles, then low; with the MDU attached, LO=0xFFFFFFEB.
- divu, `e_srca=100`, `e_srcb=7`, `d_md=1` → `stall_d` high for 11 cycles; HI=2 and LO=14 on the first unstalled cycle.
- mult, then `req` high for 3 cycles starting 2 cycles after start → `stall_d` high for 9 cycles, `cnt` frozen during `req`.
- `req=1` in the same cycle as a div in E → `mdu_start=0`, state remains IDLE, `stall_d=0` when `d_md=1`.
- With `MDU_ISSUE_CHECK_EN`: div issued, bench forces `mdu_busy=0` in the 3rd busy cycle → `proto_err=1` and stays 1 after the div completes.
- Async reset pulse in the 4th cycle of a div → `stall_d=0` within the same cycle; state IDLE after release; the next mult issues normally.

Source files
------------

// File: rtl/mdu_issue_ctrl.sv
// ----------------------------------------------------------------------------
// mdu_issue_ctrl
//
// Purpose:
//   E-stage initiator for the multiply/divide unit. Issues mult/multu/div/divu
//   to the MDU with a one-cycle start pulse and keeps a cycle-exact shadow of
//   the MDU busy window. The shadow drives the D-stage stall for MD-class
//   instructions, so HI/LO are never read or written while a result is still
//   being computed.
//
// Parameters:
//   MULT_LAT  MDU busy cycles following a mult/multu start (default 5)
//   DIV_LAT   MDU busy cycles following a div/divu start (default 10)
//
// Ports:
//   i_clk          rising-edge clock
//   i_reset        asynchronous reset, active LOW
//   i_req          exception/interrupt request; freezes MDU, blocks issue
//   i_d_md         D-stage instruction is MD-class
//   i_e_valid      E-stage instruction is valid
//   i_e_op [3:0]   E-stage MDU op (0 none, 1 mult, 2 multu, 3 div, 4 divu,
//                  5 mfhi, 6 mflo, 7 mthi, 8 mtlo)
//   i_e_srca/b     forwarded E-stage operands (32 bit)
//   i_mdu_busy     Busy returned from the MDU (checker build only)
//   o_mdu_start    start pulse to the MDU
//   o_mdu_op [3:0] op to the MDU
//   o_mdu_srca/b   operands to the MDU (32 bit)
//   o_stall_d      freeze F/D and bubble E
//   o_proto_err    sticky protocol-mismatch flag
//
// Build option:
//   MDU_ISSUE_CHECK_EN  when defined, compares i_mdu_busy against the shadow
//                       busy window and flags MD ops arriving in E while busy.
//                       When undefined, o_proto_err is tied low.
// ----------------------------------------------------------------------------
module mdu_issue_ctrl #(
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_req,
   input  logic        i_d_md,
   input  logic        i_e_valid,
   input  logic [3:0]  i_e_op,
   input  logic [31:0] i_e_srca,
   input  logic [31:0] i_e_srcb,
   input  logic        i_mdu_busy,
   output logic        o_mdu_start,
   output logic [3:0]  o_mdu_op,
   output logic [31:0] o_mdu_srca,
   output logic [31:0] o_mdu_srcb,
   output logic        o_stall_d,
   output logic        o_proto_err
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
   localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_cnt;
   logic [3:0] w_cnt_nxt;
   logic       w_is_mul_div;
   logic       w_issue;

   // Decode which E-stage ops actually need the MDU to start. The HI/LO move
   // ops never start anything; the stall keeps them out of E while busy.
   always_comb begin
      w_is_mul_div = (i_e_op >= 4'd1) && (i_e_op <= 4'd4);
   end

   // Issue and stall are combinational so the start pulse lands in the same
   // cycle the op sits in E. Both are gated by reset so they drop the moment
   // reset is asserted rather than waiting for the state register.
   always_comb begin
      w_issue     = i_reset & i_e_valid & ~i_req & (r_state == ST_IDLE) & w_is_mul_div;
      o_mdu_start = w_issue;
      o_mdu_op    = i_e_valid ? i_e_op : 4'd0;
      o_mdu_srca  = i_e_srca;
      o_mdu_srcb  = i_e_srcb;
      o_stall_d   = i_reset & i_d_md & (w_issue | (r_state == ST_RUN));
   end

   // Next-state logic. The counter is loaded with the full latency on issue
   // and counts down in RUN; a pending request freezes it because the MDU
   // itself freezes while Req is high, keeping the shadow cycle-exact.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      unique case (r_state)
         ST_IDLE: begin
            if (w_issue) begin
               w_state_nxt = ST_RUN;
               w_cnt_nxt   = (i_e_op <= 4'd2) ? MULT_CNT : DIV_CNT;
            end
         end
         ST_RUN: begin
            if (!i_req) begin
               if (r_cnt == 4'd1) begin
                  w_state_nxt = ST_IDLE;
                  w_cnt_nxt   = 4'd0;
               end else begin
                  w_cnt_nxt = r_cnt - 4'd1;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 4'd0;
         end
      endcase
   end

   // State and counter registers, cleared by the system reset shared with
   // the MDU so both sides come out of reset idle together.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

`ifdef MDU_ISSUE_CHECK_EN
   logic r_exp_busy;
   logic r_proto_err;
   logic w_busy_mismatch;
   logic w_issue_while_busy;

   // The MDU reports Busy exactly in the cycles the shadow sits in RUN, so
   // any disagreement, or a fresh mul/div arriving in E while busy (it would
   // be silently dropped), is a protocol violation.
   always_comb begin
      w_busy_mismatch    = (i_mdu_busy != r_exp_busy);
      w_issue_while_busy = i_e_valid & w_is_mul_div & (r_state == ST_RUN);
   end

   // Expected-busy shadow and the sticky error flag; only reset clears it.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_exp_busy  <= 1'b0;
         r_proto_err <= 1'b0;
      end else begin
         r_exp_busy  <= (w_state_nxt == ST_RUN);
         r_proto_err <= r_proto_err | w_busy_mismatch | w_issue_while_busy;
      end
   end

   assign o_proto_err = r_proto_err;
`else
   logic w_unused_busy;

   // Without the checker the Busy return is intentionally ignored.
   assign w_unused_busy = i_mdu_busy;
   assign o_proto_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mdu_issue_ctrl
//
// Self-checking bench for mdu_issue_ctrl. A behavioural model tracks the
// MDU as "cycles of busy remaining" and also plays the role of the MDU by
// returning Busy from that count. Directed scenarios cover mult/divu stall
// lengths, request freezing, request-blocked issue, the protocol checker
// (when MDU_ISSUE_CHECK_EN is defined) and an async reset mid-divide,
// followed by randomized traffic.
// ----------------------------------------------------------------------------
module tb_mdu_issue_ctrl;

   localparam int MULT_LAT = 5;
   localparam int DIV_LAT  = 10;

   logic        clk = 1'b0;
   logic        resetN = 1'b0;
   logic        req = 1'b0;
   logic        dMd = 1'b0;
   logic        eValid = 1'b0;
   logic [3:0]  eOp = 4'd0;
   logic [31:0] eSrca = 32'd0;
   logic [31:0] eSrcb = 32'd0;
   logic        mduBusy = 1'b0;
   logic        mduStart;
   logic [3:0]  mduOp;
   logic [31:0] mduSrca;
   logic [31:0] mduSrcb;
   logic        stallD;
   logic        protoErr;

   int checkCount = 0;
   int errorCount = 0;

   int busyLeft  = 0;
   bit modelErr  = 1'b0;

   mdu_issue_ctrl #(
      .MULT_LAT(MULT_LAT),
      .DIV_LAT (DIV_LAT)
   ) dut (
      .i_clk      (clk),
      .i_reset    (resetN),
      .i_req      (req),
      .i_d_md     (dMd),
      .i_e_valid  (eValid),
      .i_e_op     (eOp),
      .i_e_srca   (eSrca),
      .i_e_srcb   (eSrcb),
      .i_mdu_busy (mduBusy),
      .o_mdu_start(mduStart),
      .o_mdu_op   (mduOp),
      .o_mdu_srca (mduSrca),
      .o_mdu_srcb (mduSrcb),
      .o_stall_d  (stallD),
      .o_proto_err(protoErr)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic bit isMulDiv(input logic [3:0] op);
      return (op >= 4'd1) && (op <= 4'd4);
   endfunction

   // One clock cycle: drive inputs after the falling edge, compare outputs
   // against the model, then advance the model on the rising edge.
   task automatic applyStimulus(input bit r, input bit dmd, input bit v,
                                input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, input bit busyFault,
                                output bit sawStall, output bit sawStart);
      bit expIssue;
      bit expStall;
      @(negedge clk);
      req     = r;
      dMd     = dmd;
      eValid  = v;
      eOp     = op;
      eSrca   = a;
      eSrcb   = b;
      mduBusy = (busyLeft > 0) ^ busyFault;
      expIssue = v && !r && (busyLeft == 0) && isMulDiv(op);
      expStall = dmd && (expIssue || (busyLeft > 0));
      #1;
      checkOutput("mdu_start", mduStart, expIssue);
      checkOutput("stall_d", stallD, expStall);
      checkOutput("mdu_op", mduOp, v ? op : 4'd0);
      checkOutput("mdu_srca", mduSrca, a);
      checkOutput("mdu_srcb", mduSrcb, b);
      checkOutput("proto_err", protoErr, modelErr);
      sawStall = stallD;
      sawStart = mduStart;
      @(posedge clk);
`ifdef MDU_ISSUE_CHECK_EN
      if ((mduBusy != (busyLeft > 0)) || ((busyLeft > 0) && v && isMulDiv(op)))
         modelErr = 1'b1;
`endif
      if (expIssue)
         busyLeft = (op <= 4'd2) ? MULT_LAT : DIV_LAT;
      else if ((busyLeft > 0) && !r)
         busyLeft--;
   endtask

   // Hold reset for two edges with issue-like inputs present; outputs must
   // stay quiet throughout.
   task automatic resetDut();
      @(negedge clk);
      resetN = 1'b0;
      dMd    = 1'b1;
      eValid = 1'b1;
      eOp    = 4'd3;
      req    = 1'b0;
      #1;
      checkOutput("rst_start", mduStart, 1'b0);
      checkOutput("rst_stall", stallD, 1'b0);
      checkOutput("rst_proto", protoErr, 1'b0);
      @(posedge clk);
      @(negedge clk);
      checkOutput("rst_stall_hold", stallD, 1'b0);
      resetN  = 1'b1;
      dMd     = 1'b0;
      eValid  = 1'b0;
      eOp     = 4'd0;
      mduBusy = 1'b0;
      busyLeft = 0;
      modelErr = 1'b0;
   endtask

   // Issue one op in E with d_md held high, then bubbles until well past the
   // busy window; returns the number of stalled cycles and start pulses.
   task automatic runOp(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int reqFrom, input int reqTo,
                        input int faultAt, output int stallCnt, output int startCnt);
      bit st;
      bit ss;
      applyStimulus(1'b0, 1'b1, 1'b1, op, a, b, 1'b0, st, ss);
      stallCnt = st;
      startCnt = ss;
      for (int i = 1; i < 20; i++) begin
         applyStimulus((i >= reqFrom) && (i <= reqTo), 1'b1, 1'b0, 4'd0, a, b,
                       i == faultAt, st, ss);
         stallCnt += st;
         startCnt += ss;
      end
   endtask

   initial begin
      int stallCnt;
      int startCnt;
      bit st;
      bit ss;

      resetDut();

      // mult 7 * -3: one start, 6 stalled cycles.
      runOp(4'd1, 32'd7, -32'sd3, 99, 0, 99, stallCnt, startCnt);
      checkOutput("mult_stall_len", stallCnt, 6);
      checkOutput("mult_starts", startCnt, 1);

      // divu 100 / 7: 11 stalled cycles.
      runOp(4'd4, 32'd100, 32'd7, 99, 0, 99, stallCnt, startCnt);
      checkOutput("divu_stall_len", stallCnt, 11);

      // mult with req for 3 cycles starting 2 cycles after start: 9 stalls.
      runOp(4'd2, 32'h1234, 32'h5678, 2, 4, 99, stallCnt, startCnt);
      checkOutput("mult_req_stall_len", stallCnt, 9);

      // req in the would-be issue cycle blocks the div; reissue follows.
      applyStimulus(1'b1, 1'b1, 1'b1, 4'd3, 32'd50, 32'd5, 1'b0, st, ss);
      checkOutput("req_block_start", ss, 1'b0);
      checkOutput("req_block_stall", st, 1'b0);
      runOp(4'd3, 32'd50, 32'd5, 99, 0, 99, stallCnt, startCnt);
      checkOutput("reissue_stall_len", stallCnt, 11);

      // Busy forced low in the 3rd busy cycle of a div.
      runOp(4'd3, 32'd9, 32'd3, 99, 0, 3, stallCnt, startCnt);
`ifdef MDU_ISSUE_CHECK_EN
      checkOutput("proto_sticky", protoErr, 1'b1);
`else
      checkOutput("proto_tied", protoErr, 1'b0);
`endif
      resetDut();

      // Async reset in the 4th cycle of a div.
      applyStimulus(1'b0, 1'b1, 1'b1, 4'd3, 32'd1, 32'd1, 1'b0, st, ss);
      for (int i = 0; i < 2; i++)
         applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, st, ss);
      @(negedge clk);
      dMd = 1'b1;
      #1;
      checkOutput("pre_rst_stall", stallD, 1'b1);
      #1;
      resetN = 1'b0;
      #1;
      checkOutput("async_rst_stall", stallD, 1'b0);
      checkOutput("async_rst_start", mduStart, 1'b0);
      busyLeft = 0;
      modelErr = 1'b0;
      @(posedge clk);
      @(negedge clk);
      resetN  = 1'b1;
      mduBusy = 1'b0;
      runOp(4'd1, 32'd3, 32'd4, 99, 0, 99, stallCnt, startCnt);
      checkOutput("post_rst_mult_stall", stallCnt, 6);
      checkOutput("post_rst_mult_start", startCnt, 1);

      // Randomized traffic against the model.
      resetDut();
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom % 8) == 0, $urandom % 2, ($urandom % 4) != 0,
                       4'($urandom_range(0, 8)), $urandom, $urandom,
                       ($urandom % 64) == 0, st, ss);
      end

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
